gtx_prbs_test_ctrl: RTL and testbench
=====================================

Name: gtx_prbs_test_ctrl

Overview:
- Sequencer for one GTX PRBS receive checker on the CFEB link path.
- Holds the checker in reset, arms it, and waits for the 48-bit start pattern.
- Counts checked words and mismatches over a programmed window, then reports pass, fail, timeout or stop.
- Sits between the slow-control command/status registers and the checker. The checker's RST input is driven by chk_rst. Its STRT_MTCH, VALID and MATCH outputs feed this block.

Parameters:
- TEST_LEN, 32'd1000000: number of VALID words to check before DONE.
- START_TIMEOUT, 16'd4096: CE3 strobes allowed in ARM before giving up.
- ERR_ABORT, 16'd0: early exit once err_cnt equals this value; 0 disables early exit.

Ports:
- REC_CLK  in  1  recovered 160 MHz clock
- RST  in  1  reset
- CE3  in  1  word strobe, one REC_CLK cycle in three; all checker inputs are sampled only when CE3=1
- cmd_start  in  1  single-cycle start pulse
- cmd_stop  in  1  single-cycle stop pulse
- strt_mtch  in  1  checker start-pattern detect
- valid  in  1  checker valid
- match  in  1  checker match
- chk_rst  out  1  reset to the checker
- state  out  3  IDLE=0, CLR=1, ARM=2, RUN=3, DONE=4
- busy  out  1  state is CLR, ARM or RUN
- done  out  1  state is DONE
- pass  out  1  window completed with err_cnt=0
- fail  out  1  window completed with err_cnt>0, or early abort, or timeout
- timeout  out  1  start pattern not found within START_TIMEOUT
- stopped  out  1  run ended by cmd_stop
- word_cnt  out  32  VALID words checked
- err_cnt  out  16  mismatching words, saturates at 16'hFFFF
- first_err  out  32  word_cnt value at the first mismatch

Behaviour:
- Reset: RST, asynchronous, active-high; clock REC_CLK. On reset:
  - state=IDLE, chk_rst=1.
  - All counters, first_err and flags = 0.
- IDLE:
  - chk_rst=1.
  - cmd_start -> CLR on the next REC_CLK edge, independent of CE3.
- CLR:
  - Clears word_cnt, err_cnt, first_err, pass, fail, timeout and stopped.
  - chk_rst=1 for two CE3 strobes; the checker sees at least one CE3 while in reset.
  - After the 2nd CE3 strobe -> ARM.
- ARM:
  - chk_rst=0; 16-bit tmo counter cleared on entry.
  - On each CE3: if strt_mtch=1 -> RUN; else tmo increments.
  - When tmo reaches START_TIMEOUT -> DONE with timeout=1 and fail=1.
- RUN:
  - On each CE3 with valid=1: word_cnt increments.
  - If match=0 on such a word, err_cnt increments (saturating).
  - If that mismatch is the first one (err_cnt was 0), first_err captures the pre-increment word_cnt value.
  - valid=0 words are not counted. This covers the checker re-syncing on a repeated start pattern.
  - Transition to DONE on the CE3 edge that makes word_cnt equal TEST_LEN:
    - pass=(err_cnt_next==0)
    - fail=!pass
  - ERR_ABORT!=0 and err_cnt_next==ERR_ABORT -> DONE with fail=1, pass=0. If this coincides with TEST_LEN, the result is still fail.
- cmd_stop:
  - In CLR, ARM or RUN -> DONE with stopped=1, pass=0, fail=0. Counters are frozen at their current values.
  - cmd_stop together with cmd_start in the same cycle: stop wins.
- cmd_start while busy: ignored.
- DONE:
  - chk_rst=0; results are held.
  - cmd_start -> CLR (a new run).
  - cmd_stop -> IDLE. Flags clear; counters are retained for readout.
- Latency: done asserts on the REC_CLK edge of the terminating CE3 sample. All outputs are registered.
- Width rules:
  - TEST_LEN=0 is treated as 1.
  - word_cnt never exceeds TEST_LEN.
  - err_cnt saturates and does not wrap.
- Reset mid-run: immediate return to IDLE, with all outputs at their reset values.

Decomposition:
- Shared package gtx_prbs_pkg holds the state encodings (IDLE..DONE) and the counter widths (WORD_CNT_W=32, ERR_CNT_W=16, TMO_W=16).
- No sub-module.
- A saturating counter is inline logic, not a separate module.

Test Plan:
1. Sim parameters TEST_LEN=16, START_TIMEOUT=8. cmd_start, start pattern on the 3rd ARM CE3, then 16 valid words with match=1 -> done=1, pass=1, word_cnt=16, err_cnt=0.
2. Same as 1, with match=0 on words 5 and 11 -> fail=1, err_cnt=2, first_err=4.
3. cmd_start with no start pattern -> after 8 ARM CE3 strobes: done=1, timeout=1, fail=1, word_cnt=0.
4. ERR_ABORT=3, match=0 on words 0-3 -> DONE after word 2, err_cnt=3, word_cnt=3, fail=1.
5. cmd_stop after 7 words, then cmd_start and cmd_stop in the same cycle while busy -> stopped=1, pass=fail=0, word_cnt=7. The second command pair has no effect.
6. RST asserted mid-RUN (word_cnt=9) -> state=0, chk_rst=1, all counters 0 asynchronously. A subsequent cmd_start runs clean to pass.

Source files
------------

// File: rtl/gtx_prbs_pkg.sv
// ---------------------------------------------------------------------------
// gtx_prbs_pkg
// Shared definitions for the GTX PRBS test sequencer: the sequencer state
// encoding (also visible on the status register as a 3-bit code) and the
// widths of the word, error and start-timeout counters.
// ---------------------------------------------------------------------------
package gtx_prbs_pkg;

   localparam int WORD_CNT_W = 32;
   localparam int ERR_CNT_W  = 16;
   localparam int TMO_W      = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_ARM  = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/gtx_prbs_test_ctrl.sv
// ---------------------------------------------------------------------------
// gtx_prbs_test_ctrl
// Sequencer for one GTX PRBS receive checker on the CFEB link path. It holds
// the checker in reset, arms it, waits for the start pattern, then counts
// checked words and mismatches over a programmed window and reports pass,
// fail, timeout or stop.
//
// Ports:
//   REC_CLK    recovered 160 MHz clock
//   RST        asynchronous active-high reset
//   CE3        word strobe (one REC_CLK in three); checker inputs are only
//              sampled while CE3=1
//   cmd_start  single-cycle start pulse from slow control
//   cmd_stop   single-cycle stop pulse from slow control
//   strt_mtch  checker start-pattern detect
//   valid      checker word valid
//   match      checker word match
//   chk_rst    reset to the checker
//   state      sequencer state code (IDLE=0 CLR=1 ARM=2 RUN=3 DONE=4)
//   busy       state is CLR, ARM or RUN
//   done       state is DONE
//   pass/fail/timeout/stopped   result flags
//   word_cnt   valid words checked
//   err_cnt    mismatching words, saturating
//   first_err  word_cnt value at the first mismatch
// ---------------------------------------------------------------------------
module gtx_prbs_test_ctrl
   import gtx_prbs_pkg::*;
#(
   parameter logic [WORD_CNT_W-1:0] TEST_LEN      = 32'd1000000,
   parameter logic [TMO_W-1:0]      START_TIMEOUT = 16'd4096,
   parameter logic [ERR_CNT_W-1:0]  ERR_ABORT     = 16'd0
)(
   input  logic                  REC_CLK,
   input  logic                  RST,
   input  logic                  CE3,
   input  logic                  cmd_start,
   input  logic                  cmd_stop,
   input  logic                  strt_mtch,
   input  logic                  valid,
   input  logic                  match,
   output logic                  chk_rst,
   output logic [2:0]            state,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic                  timeout,
   output logic                  stopped,
   output logic [WORD_CNT_W-1:0] word_cnt,
   output logic [ERR_CNT_W-1:0]  err_cnt,
   output logic [WORD_CNT_W-1:0] first_err
);

   // A zero-length window would never terminate, so it runs as one word.
   localparam logic [WORD_CNT_W-1:0] EFF_LEN =
      (TEST_LEN == '0) ? WORD_CNT_W'(1) : TEST_LEN;

   state_t                  state_q, state_d;
   logic                    clr_cnt_q, clr_cnt_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
   logic [WORD_CNT_W-1:0]   first_err_q, first_err_d;
   logic                    pass_q, pass_d;
   logic                    fail_q, fail_d;
   logic                    timeout_q, timeout_d;
   logic                    stopped_q, stopped_d;
   logic                    chk_rst_q, chk_rst_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic                    word_strobe;
   logic [WORD_CNT_W-1:0]   word_inc;
   logic [ERR_CNT_W-1:0]    err_inc;
   logic [ERR_CNT_W-1:0]    err_next;
   logic                    len_hit;
   logic                    abort_hit;
   logic [TMO_W-1:0]        tmo_inc;
   logic                    tmo_hit;

   // Per-word terms shared by the next-state and datapath logic. The error
   // counter sticks at all-ones instead of wrapping. The timeout compare uses
   // >= so that a zero timeout gives up on the first unmatched strobe.
   assign word_strobe = CE3 && valid;
   assign word_inc    = word_cnt_q + WORD_CNT_W'(1);
   assign err_inc     = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
   assign err_next    = match ? err_cnt_q : err_inc;
   assign len_hit     = (word_inc == EFF_LEN);
   assign abort_hit   = (ERR_ABORT != '0) && (err_next == ERR_ABORT);
   assign tmo_inc     = tmo_q + TMO_W'(1);
   assign tmo_hit     = (tmo_inc >= START_TIMEOUT);

   // State register. Reset returns straight to IDLE regardless of the clock.
   always_ff @(posedge REC_CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Commands act on any REC_CLK edge; checker inputs only
   // on CE3 strobes. A stop in the same cycle as a start always wins.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_start && !cmd_stop) state_d = ST_CLR;
         end
         ST_CLR: begin
            if (cmd_stop)                state_d = ST_DONE;
            else if (CE3 && clr_cnt_q)   state_d = ST_ARM;
         end
         ST_ARM: begin
            if (cmd_stop)                state_d = ST_DONE;
            else if (CE3 && strt_mtch)   state_d = ST_RUN;
            else if (CE3 && tmo_hit)     state_d = ST_DONE;
         end
         ST_RUN: begin
            if (cmd_stop)                                   state_d = ST_DONE;
            else if (word_strobe && (len_hit || abort_hit)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (cmd_stop)                state_d = ST_IDLE;
            else if (cmd_start)          state_d = ST_CLR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath logic. Status decodes are taken from the next state
   // so every output comes straight from a flop. Counters only move on
   // strobes that are not overridden by a stop, which freezes them at the
   // value seen when the stop arrived. Entering CLR wipes the previous run's
   // results, and entering ARM restarts the start-pattern timeout.
   always_comb begin
      clr_cnt_d   = clr_cnt_q;
      tmo_d       = tmo_q;
      word_cnt_d  = word_cnt_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      stopped_d   = stopped_q;
      chk_rst_d   = (state_d == ST_IDLE) || (state_d == ST_CLR);
      busy_d      = (state_d == ST_CLR) || (state_d == ST_ARM) || (state_d == ST_RUN);
      done_d      = (state_d == ST_DONE);

      case (state_q)
         ST_CLR: begin
            if (cmd_stop)  stopped_d = 1'b1;
            else if (CE3)  clr_cnt_d = 1'b1;
         end
         ST_ARM: begin
            if (cmd_stop) begin
               stopped_d = 1'b1;
            end else if (CE3 && !strt_mtch) begin
               tmo_d = tmo_inc;
               if (tmo_hit) begin
                  timeout_d = 1'b1;
                  fail_d    = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (cmd_stop) begin
               stopped_d = 1'b1;
            end else if (word_strobe) begin
               word_cnt_d = word_inc;
               err_cnt_d  = err_next;
               if (!match && (err_cnt_q == '0)) first_err_d = word_cnt_q;
               if (abort_hit) begin
                  pass_d = 1'b0;
                  fail_d = 1'b1;
               end else if (len_hit) begin
                  pass_d = (err_next == '0);
                  fail_d = (err_next != '0);
               end
            end
         end
         ST_DONE: begin
            if (cmd_stop) begin
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               timeout_d = 1'b0;
               stopped_d = 1'b0;
            end
         end
         default: ;
      endcase

      if ((state_d == ST_CLR) && (state_q != ST_CLR)) begin
         clr_cnt_d   = 1'b0;
         word_cnt_d  = '0;
         err_cnt_d   = '0;
         first_err_d = '0;
         pass_d      = 1'b0;
         fail_d      = 1'b0;
         timeout_d   = 1'b0;
         stopped_d   = 1'b0;
      end
      if ((state_d == ST_ARM) && (state_q != ST_ARM)) begin
         tmo_d = '0;
      end
   end

   // Datapath and status registers. The checker is held in reset out of
   // reset so it never runs unsupervised.
   always_ff @(posedge REC_CLK or posedge RST) begin
      if (RST) begin
         clr_cnt_q   <= 1'b0;
         tmo_q       <= '0;
         word_cnt_q  <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         stopped_q   <= 1'b0;
         chk_rst_q   <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         clr_cnt_q   <= clr_cnt_d;
         tmo_q       <= tmo_d;
         word_cnt_q  <= word_cnt_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
         stopped_q   <= stopped_d;
         chk_rst_q   <= chk_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign state     = state_q;
   assign chk_rst   = chk_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign timeout   = timeout_q;
   assign stopped   = stopped_q;
   assign word_cnt  = word_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign first_err = first_err_q;

endmodule

// File: tb/tb_gtx_prbs_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gtx_prbs_test_ctrl
// Bench for the GTX PRBS test sequencer. Each run is described as a list of
// checker words; a reference model walks that list to predict the result,
// which is queued, and a monitor compares it when done rises.
// ---------------------------------------------------------------------------
module tb_gtx_prbs_test_ctrl;

   localparam logic [31:0] TL  = 32'd16;
   localparam logic [15:0] STO = 16'd8;
   localparam logic [15:0] EA  = 16'd3;

   logic        REC_CLK   = 1'b0;
   logic        RST       = 1'b1;
   logic        CE3       = 1'b0;
   logic        cmd_start = 1'b0;
   logic        cmd_stop  = 1'b0;
   logic        strt_mtch = 1'b0;
   logic        valid     = 1'b0;
   logic        match     = 1'b0;
   logic        chk_rst;
   logic [2:0]  state;
   logic        busy;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic        stopped;
   logic [31:0] word_cnt;
   logic [15:0] err_cnt;
   logic [31:0] first_err;

   typedef struct {
      logic v;
      logic m;
   } word_t;

   typedef struct {
      logic pass_f;
      logic fail_f;
      logic tmo_f;
      logic stop_f;
      int   words;
      int   errs;
      int   first;
   } exp_t;

   word_t evq[$];
   exp_t  exp_q[$];
   exp_t  mon_e;
   int    checks = 0;
   int    errors = 0;
   int    ce_phase = 0;
   logic  done_prev = 1'b0;

   gtx_prbs_test_ctrl #(
      .TEST_LEN      (TL),
      .START_TIMEOUT (STO),
      .ERR_ABORT     (EA)
   ) dut (
      .REC_CLK   (REC_CLK),
      .RST       (RST),
      .CE3       (CE3),
      .cmd_start (cmd_start),
      .cmd_stop  (cmd_stop),
      .strt_mtch (strt_mtch),
      .valid     (valid),
      .match     (match),
      .chk_rst   (chk_rst),
      .state     (state),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail      (fail),
      .timeout   (timeout),
      .stopped   (stopped),
      .word_cnt  (word_cnt),
      .err_cnt   (err_cnt),
      .first_err (first_err)
   );

   // Recovered clock.
   always #3 REC_CLK = ~REC_CLK;

   // Free-running one-in-three word strobe, updated just after each edge.
   initial begin
      forever begin
         @(posedge REC_CLK);
         #1;
         ce_phase = (ce_phase + 1) % 3;
         CE3 = (ce_phase == 0);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every rising edge of done retires one queued expectation.
   initial begin
      forever begin
         @(negedge REC_CLK);
         if (!RST && done && !done_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: actual=done required=no_done");
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("done_pass",      32'(pass),      32'(mon_e.pass_f));
               checkOutput("done_fail",      32'(fail),      32'(mon_e.fail_f));
               checkOutput("done_timeout",   32'(timeout),   32'(mon_e.tmo_f));
               checkOutput("done_stopped",   32'(stopped),   32'(mon_e.stop_f));
               checkOutput("done_word_cnt",  word_cnt,       mon_e.words);
               checkOutput("done_err_cnt",   32'(err_cnt),   mon_e.errs);
               checkOutput("done_first_err", first_err,      mon_e.first);
               checkOutput("done_chk_rst",   32'(chk_rst),   32'd0);
               checkOutput("done_busy",      32'(busy),      32'd0);
            end
         end
         done_prev = done;
      end
   end

   // Reference model: walk the word list, applying the window, abort and
   // stop rules, and report the predicted result and the words consumed.
   function automatic void runModel(input int stop_after, output exp_t e, output int consumed);
      int k;
      k = 0;
      consumed = 0;
      e = '{default: 0};
      for (int i = 0; i < evq.size(); i++) begin
         if (stop_after >= 0 && k == stop_after) begin
            e.stop_f = 1'b1;
            break;
         end
         consumed++;
         if (evq[i].v) begin
            if (!evq[i].m) begin
               if (e.errs == 0) e.first = k;
               if (e.errs < 65535) e.errs++;
            end
            k++;
            if (EA != 0 && e.errs == int'(EA)) begin
               e.fail_f = 1'b1;
               break;
            end
            if (k == int'(TL)) begin
               e.pass_f = (e.errs == 0);
               e.fail_f = (e.errs != 0);
               break;
            end
         end
      end
      e.words = k;
   endfunction

   // Build a window of TL valid words with random invalid gaps; mask forces
   // mismatches on chosen valid-word indices, err_pct adds random ones.
   task automatic buildEvents(input int gap_pct, input int err_pct, input logic [31:0] mask);
      word_t w;
      evq.delete();
      for (int i = 0; i < int'(TL); i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            w.v = 1'b0;
            w.m = 1'($urandom_range(1));
            evq.push_back(w);
         end
         w.v = 1'b1;
         w.m = !(mask[i] || (int'($urandom_range(99)) < err_pct));
         evq.push_back(w);
      end
   endtask

   task automatic pulseCmd(input logic s, input logic p);
      strt_mtch = 1'b0;
      valid     = 1'b0;
      match     = 1'b0;
      cmd_start = s;
      cmd_stop  = p;
      @(posedge REC_CLK);
      #2;
      cmd_start = 1'b0;
      cmd_stop  = 1'b0;
   endtask

   task automatic nextStrobe(input logic sm, input logic v, input logic m);
      while (!CE3) begin
         @(posedge REC_CLK);
         #2;
      end
      strt_mtch = sm;
      valid     = v;
      match     = m;
      @(posedge REC_CLK);
      #2;
      strt_mtch = 1'b0;
      valid     = 1'b0;
      match     = 1'b0;
   endtask

   // One complete run: start, two CLR strobes, ARM phase, RUN words, and
   // an optional stop or reset; finally a stop back to IDLE.
   task automatic applyStimulus(input int arm_delay, input bit tmo_case, input int stop_after,
                                input bit stop_with_start, input int reset_after);
      exp_t e;
      int   consumed;
      if (tmo_case) begin
         e = '{default: 0};
         e.tmo_f  = 1'b1;
         e.fail_f = 1'b1;
         consumed = 0;
      end else begin
         runModel((reset_after >= 0) ? reset_after : stop_after, e, consumed);
      end
      if (reset_after < 0) exp_q.push_back(e);

      pulseCmd(1'b1, 1'b0);
      checkOutput("clr_state",    32'(state),   32'd1);
      checkOutput("clr_chk_rst",  32'(chk_rst), 32'd1);
      checkOutput("clr_busy",     32'(busy),    32'd1);
      checkOutput("clr_word_cnt", word_cnt,     32'd0);
      checkOutput("clr_flags",    32'({pass, fail, timeout, stopped}), 32'd0);
      nextStrobe(1'b0, 1'b0, 1'b0);
      checkOutput("clr_hold",     32'(state),   32'd1);
      nextStrobe(1'b0, 1'b0, 1'b0);
      checkOutput("arm_state",    32'(state),   32'd2);
      checkOutput("arm_chk_rst",  32'(chk_rst), 32'd0);

      if (tmo_case) begin
         for (int i = 0; i < int'(STO); i++) nextStrobe(1'b0, 1'b0, 1'b0);
      end else begin
         for (int i = 0; i < arm_delay; i++) nextStrobe(1'b0, 1'b0, 1'b0);
         nextStrobe(1'b1, 1'b0, 1'b0);
         checkOutput("run_state", 32'(state), 32'd3);
         pulseCmd(1'b1, 1'b0);
         checkOutput("busy_start_ignored", 32'(state), 32'd3);
         for (int i = 0; i < consumed; i++)
            nextStrobe(1'($urandom_range(1)), evq[i].v, evq[i].m);
         if (reset_after >= 0) begin
            RST = 1'b1;
            #1;
            checkOutput("rst_state",     32'(state),   32'd0);
            checkOutput("rst_chk_rst",   32'(chk_rst), 32'd1);
            checkOutput("rst_word_cnt",  word_cnt,     32'd0);
            checkOutput("rst_err_cnt",   32'(err_cnt), 32'd0);
            checkOutput("rst_first_err", first_err,    32'd0);
            checkOutput("rst_flags",     32'({busy, done, pass, fail, timeout, stopped}), 32'd0);
            @(posedge REC_CLK);
            #2;
            RST = 1'b0;
            return;
         end
         if (stop_after >= 0) begin
            pulseCmd(stop_with_start, 1'b1);
            checkOutput("stop_state", 32'(state), 32'd4);
         end
      end

      pulseCmd(1'b0, 1'b1);
      checkOutput("idle_state",    32'(state),   32'd0);
      checkOutput("idle_chk_rst",  32'(chk_rst), 32'd1);
      checkOutput("idle_flags",    32'({busy, done, pass, fail, timeout, stopped}), 32'd0);
      checkOutput("idle_word_cnt", word_cnt,     e.words);
      checkOutput("idle_err_cnt",  32'(err_cnt), e.errs);
   endtask

   initial begin
      repeat (2) @(posedge REC_CLK);
      #2;
      checkOutput("reset_state",    32'(state),   32'd0);
      checkOutput("reset_chk_rst",  32'(chk_rst), 32'd1);
      checkOutput("reset_word_cnt", word_cnt,     32'd0);
      checkOutput("reset_err_cnt",  32'(err_cnt), 32'd0);
      checkOutput("reset_flags",    32'({busy, done, pass, fail, timeout, stopped}), 32'd0);
      RST = 1'b0;

      $display("[TB] clean window");
      buildEvents(0, 0, 32'h0);
      applyStimulus(2, 1'b0, -1, 1'b0, -1);

      $display("[TB] two mismatches");
      buildEvents(0, 0, 32'h0000_0410);
      applyStimulus(2, 1'b0, -1, 1'b0, -1);

      $display("[TB] start timeout");
      applyStimulus(0, 1'b1, -1, 1'b0, -1);

      $display("[TB] error abort");
      buildEvents(0, 0, 32'h0000_000F);
      applyStimulus(1, 1'b0, -1, 1'b0, -1);

      $display("[TB] stop with start after 7 words");
      buildEvents(20, 0, 32'h0);
      applyStimulus(0, 1'b0, 7, 1'b1, -1);

      $display("[TB] start found on last ARM strobe");
      buildEvents(10, 0, 32'h0);
      applyStimulus(int'(STO) - 1, 1'b0, -1, 1'b0, -1);

      $display("[TB] reset mid-run then clean run");
      buildEvents(0, 0, 32'h0);
      applyStimulus(3, 1'b0, -1, 1'b0, 9);
      buildEvents(0, 0, 32'h0);
      applyStimulus(4, 1'b0, -1, 1'b0, -1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 10; r++) begin
         buildEvents(int'($urandom_range(40)), int'($urandom_range(8)), 32'h0);
         applyStimulus(int'($urandom_range(int'(STO) - 1)), 1'b0,
                       ($urandom_range(3) == 0) ? int'($urandom_range(int'(TL) - 1)) : -1,
                       1'($urandom_range(1)), -1);
      end

      repeat (6) @(posedge REC_CLK);
      #2;
      checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
